// File: rtl/uart_rx_param_if.sv
// Received-word handshake bundle between the UART receive engine and its consumer.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_overrun;

  modport master (
    output o_data, o_valid, o_parity_err, o_frame_err, o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_parity_err, o_frame_err, o_overrun,
    output i_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, glitch filter, mid-bit sampling FSM
// and a valid/ready output register with per-word error flags and sticky overrun.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILTER_LEN   = 4
) (
  input  logic             internal_clk,
  input  logic             i_rst,
  input  logic             i_rx,
  output logic             o_busy,
  uart_rx_param_if.master  rx_if
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned FLT_W = $clog2(FILTER_LEN);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(FILTER_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rx;
  logic [FLT_W-1:0]       flt_cnt_q;
  logic                   rx_f;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic [DATA_BITS-1:0]   out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_perr_q, out_perr_d;
  logic                   out_ferr_q, out_ferr_d;
  logic                   out_ovr_q, out_ovr_d;

  logic                   tick;
  logic                   ones_odd;
  logic                   accept;
  logic                   drop;

  // Synchroniser chain, idles high like the line
  always_ff @(posedge internal_clk or posedge i_rst) begin
    if (i_rst) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
  end
  assign sync_rx = sync_q[SYNC_STAGES-1];

  // rx_f follows the synchronised line only after FILTER_LEN agreeing samples
  always_ff @(posedge internal_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_f      <= 1'b1;
      flt_cnt_q <= '0;
    end else if (sync_rx == rx_f) begin
      flt_cnt_q <= '0;
    end else if (flt_cnt_q == FLT_LAST) begin
      rx_f      <= sync_rx;
      flt_cnt_q <= '0;
    end else begin
      flt_cnt_q <= flt_cnt_q + FLT_W'(1);
    end
  end

  always_ff @(posedge internal_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_perr_q  <= 1'b0;
      out_ferr_q  <= 1'b0;
      out_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_perr_q  <= out_perr_d;
      out_ferr_q  <= out_ferr_d;
      out_ovr_q   <= out_ovr_d;
    end
  end

  assign tick     = (cnt_q == '0);
  assign ones_odd = ^{shift_q, rx_f};
  assign accept   = out_valid_q & rx_if.i_ready;
  assign drop     = done_q & out_valid_q & ~accept;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q - CNT_W'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    done_d      = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_perr_d  = out_perr_q;
    out_ferr_d  = out_ferr_q;
    out_ovr_d   = out_ovr_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (!rx_f) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
          idx_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          cnt_d   = FULL_LOAD;
          state_d = rx_f ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_d   = FULL_LOAD;
          shift_d = {rx_f, shift_q[DATA_BITS-1:1]};
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          cnt_d   = FULL_LOAD;
          perr_d  = (PARITY == 1) ? ~ones_odd : ones_odd;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          cnt_d = FULL_LOAD;
          if (!rx_f) ferr_d = 1'b1;
          if (idx_q == LAST_STOP) begin
            done_d  = 1'b1;
            // A low final stop may be a break: wait for the line to recover
            state_d = rx_f ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = cnt_q;
        if (rx_f) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Completed frame loads the holding register unless an unaccepted word blocks it
    if (drop)        out_ovr_d = 1'b1;
    else if (accept) out_ovr_d = 1'b0;

    if (done_q && !drop) begin
      out_valid_d = 1'b1;
      out_data_d  = shift_q;
      out_perr_d  = perr_q;
      out_ferr_d  = ferr_q;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    busy_d = done_d || ((state_d != ST_IDLE) && (state_d != ST_WAIT_IDLE));
  end

  assign o_busy             = busy_q;
  assign rx_if.o_data       = out_data_q;
  assign rx_if.o_valid      = out_valid_q;
  assign rx_if.o_parity_err = out_perr_q;
  assign rx_if.o_frame_err  = out_ferr_q;
  assign rx_if.o_overrun    = out_ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and a 7E1 instance driven with
// directed and random frames, checked against frame-level expectations.
module tb_uart_rx_param;

  localparam int C   = 16;
  localparam int LAT = C / 2 + 9 * C + 1;  // both instances: 9 post-start bits

  logic internal_clk = 1'b0;
  always #5 internal_clk = ~internal_clk;

  logic i_rst = 1'b1;
  logic rx    = 1'b1;
  logic rx_p  = 1'b1;
  logic rdy   = 1'b1;
  logic rdy_p = 1'b1;
  logic busy, busy_p;

  uart_rx_param_if #(.DATA_BITS(8)) bus   ();
  uart_rx_param_if #(.DATA_BITS(7)) bus_p ();
  assign bus.i_ready   = rdy;
  assign bus_p.i_ready = rdy_p;

  uart_rx_param #(
    .CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .SYNC_STAGES(2), .FILTER_LEN(4)
  ) dut (
    .internal_clk(internal_clk), .i_rst(i_rst), .i_rx(rx), .o_busy(busy),
    .rx_if(bus.master)
  );

  uart_rx_param #(
    .CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1),
    .SYNC_STAGES(2), .FILTER_LEN(4)
  ) dut_p (
    .internal_clk(internal_clk), .i_rst(i_rst), .i_rx(rx_p), .o_busy(busy_p),
    .rx_if(bus_p.master)
  );

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         lat;
  } word_t;

  word_t wq[$];
  word_t wq_p[$];
  int    cyc = 0;
  int    passes = 0, fails = 0, total = 0;
  int    busy_rise = 0, busy_fall = 0, busy_rises = 0, busy_rise_p = 0;
  int    valid_cycles = 0;
  logic  pv = 1'b0, pv_p = 1'b0, pb = 1'b0, pb_p = 1'b0;

  always @(posedge internal_clk) cyc <= cyc + 1;

  // Edge bookkeeping: cyc at a negedge is the index of the preceding rising edge
  always @(negedge internal_clk) begin
    word_t w;
    if (busy === 1'b1 && !pb) begin busy_rise = cyc; busy_rises++; end
    if (busy === 1'b0 && pb)  busy_fall = cyc;
    if (busy_p === 1'b1 && !pb_p) busy_rise_p = cyc;
    if (bus.o_valid === 1'b1) valid_cycles++;
    if (bus.o_valid === 1'b1 && !pv) begin
      w.data = 9'(bus.o_data); w.perr = bus.o_parity_err;
      w.ferr = bus.o_frame_err; w.lat = cyc - busy_rise;
      wq.push_back(w);
    end
    if (bus_p.o_valid === 1'b1 && !pv_p) begin
      w.data = 9'(bus_p.o_data); w.perr = bus_p.o_parity_err;
      w.ferr = bus_p.o_frame_err; w.lat = cyc - busy_rise_p;
      wq_p.push_back(w);
    end
    pb = (busy === 1'b1); pb_p = (busy_p === 1'b1);
    pv = (bus.o_valid === 1'b1); pv_p = (bus_p.o_valid === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input bit which, input logic b);
    if (which) rx_p = b; else rx = b;
    repeat (C) @(posedge internal_clk);
    #1;
  endtask

  // One frame: start, nbits data LSB first, optional parity (pbit<0 = none), one stop
  task automatic send(input bit which, input logic [8:0] d, input int nbits,
                      input int pbit, input logic stop_lvl, input logic final_lvl);
    @(posedge internal_clk); #1;
    bit_out(which, 1'b0);
    for (int i = 0; i < nbits; i++) bit_out(which, d[i]);
    if (pbit >= 0) bit_out(which, pbit[0]);
    bit_out(which, stop_lvl);
    if (which) rx_p = final_lvl; else rx = final_lvl;
  endtask

  task automatic expect_word(input bit which, input string tag, input logic [8:0] d,
                             input logic pe, input logic fe);
    word_t w;
    int    n = 0;
    w.data = '0; w.perr = 1'b0; w.ferr = 1'b0; w.lat = -1;
    while (((which ? wq_p.size() : wq.size()) == 0) && n < 400) begin
      @(negedge internal_clk); n++;
    end
    chk({tag, "_arrived"}, 32'((which ? wq_p.size() : wq.size()) != 0), 32'd1);
    if (which && wq_p.size() != 0) w = wq_p.pop_front();
    else if (!which && wq.size() != 0) w = wq.pop_front();
    chk({tag, "_data"}, 32'(w.data), 32'(d));
    chk({tag, "_perr"}, 32'(w.perr), 32'(pe));
    chk({tag, "_ferr"}, 32'(w.ferr), 32'(fe));
    chk({tag, "_latency"}, 32'(w.lat), 32'(LAT));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},  32'(bus.o_data), 32'd0);
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    chk({tag, "_perr"},  32'(bus.o_parity_err), 32'd0);
    chk({tag, "_ferr"},  32'(bus.o_frame_err), 32'd0);
    chk({tag, "_ovr"},   32'(bus.o_overrun), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", passes, total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] d;
    logic       st, pb_bit, pe;
    int         n0, n, target, t0;

    repeat (3) @(posedge internal_clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_p_valid", 32'(bus_p.o_valid), 32'd0);
    i_rst = 1'b0;
    repeat (10) @(posedge internal_clk);
    #1;

    // Basic 8N1 frame
    valid_cycles = 0;
    send(1'b0, 9'h0A5, 8, -1, 1'b1, 1'b1);
    expect_word(1'b0, "basic", 9'h0A5, 1'b0, 1'b0);
    repeat (20) @(posedge internal_clk);
    #1;
    chk("basic_valid_cycles", 32'(valid_cycles), 32'd1);

    // Random 8N1 frames, occasionally with a low stop bit
    for (int i = 0; i < 8; i++) begin
      d  = 9'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      send(1'b0, d, 8, -1, st, 1'b1);
      expect_word(1'b0, "rand8n1", d, 1'b0, ~st);
      repeat (2 * C) @(posedge internal_clk);
      #1;
    end

    // 7E1: directed parity cases, then random parity bits
    send(1'b1, 9'h035, 7, 0, 1'b1, 1'b1);
    expect_word(1'b1, "even_ok", 9'h035, 1'b0, 1'b0);
    repeat (2 * C) @(posedge internal_clk);
    send(1'b1, 9'h035, 7, 1, 1'b1, 1'b1);
    expect_word(1'b1, "even_bad", 9'h035, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      repeat (2 * C) @(posedge internal_clk);
      d      = 9'($urandom_range(0, 127));
      pb_bit = 1'($urandom_range(0, 1));
      pe     = ((($countones(d) + int'(pb_bit)) % 2) != 0);
      send(1'b1, d, 7, int'(pb_bit), 1'b1, 1'b1);
      expect_word(1'b1, "rand7e1", d, pe, 1'b0);
    end

    // Frame error followed by a long break
    repeat (2 * C) @(posedge internal_clk);
    send(1'b0, 9'h055, 8, -1, 1'b0, 1'b0);
    expect_word(1'b0, "break_word", 9'h055, 1'b0, 1'b1);
    n0 = busy_rises;
    repeat (40 * C) @(posedge internal_clk);
    #1;
    chk("break_no_valid", 32'(wq.size()), 32'd0);
    chk("break_no_busy", 32'(busy_rises), 32'(n0));
    rx = 1'b1;
    repeat (2 * C) @(posedge internal_clk);
    send(1'b0, 9'h00F, 8, -1, 1'b1, 1'b1);
    expect_word(1'b0, "after_break", 9'h00F, 1'b0, 1'b0);

    // Glitch rejection and false start
    repeat (2 * C) @(posedge internal_clk);
    #1;
    n0 = busy_rises;
    rx = 1'b0;
    repeat (3) @(posedge internal_clk);
    #1;
    rx = 1'b1;
    repeat (30) @(posedge internal_clk);
    #1;
    chk("glitch3_no_busy", 32'(busy_rises), 32'(n0));
    rx = 1'b0;
    repeat (6) @(posedge internal_clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge internal_clk);
    #1;
    chk("false_start_busy", 32'(busy_rises), 32'(n0 + 1));
    chk("false_start_len", 32'(busy_fall - busy_rise), 32'(C / 2));
    chk("false_start_busy_low", 32'(busy), 32'd0);
    chk("false_start_no_word", 32'(wq.size()), 32'd0);

    // Overrun: consumer stalled across two frames
    rdy = 1'b0;
    send(1'b0, 9'h011, 8, -1, 1'b1, 1'b1);
    send(1'b0, 9'h022, 8, -1, 1'b1, 1'b1);
    repeat (40) @(posedge internal_clk);
    #1;
    chk("ovr_valid", 32'(bus.o_valid), 32'd1);
    chk("ovr_data", 32'(bus.o_data), 32'h11);
    chk("ovr_flag", 32'(bus.o_overrun), 32'd1);
    rdy = 1'b1;
    @(posedge internal_clk);
    #1;
    rdy = 1'b0;
    chk("ovr_accept_valid", 32'(bus.o_valid), 32'd0);
    chk("ovr_accept_flag", 32'(bus.o_overrun), 32'd0);
    chk("ovr_words_seen", 32'(wq.size()), 32'd1);
    wq.delete();
    rdy = 1'b1;

    // Reset asserted at the data bit 3 sample of 0xFF
    repeat (2 * C) @(posedge internal_clk);
    #1;
    rx = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 50) begin @(negedge internal_clk); n++; end
    chk("rst_frame_busy", 32'(busy), 32'd1);
    t0 = busy_rise;
    target = t0 + C / 2 + 4 * C;
    while (cyc < C + t0 - 8) @(negedge internal_clk);
    rx = 1'b1;
    n = 0;
    while (cyc < target - 1 && n < 200) begin @(negedge internal_clk); n++; end
    i_rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    repeat (3) @(posedge internal_clk);
    #1;
    i_rst = 1'b0;
    repeat (12 * C) @(posedge internal_clk);
    #1;
    chk("midreset_no_word", 32'(wq.size()), 32'd0);
    chk("midreset_idle", 32'(busy), 32'd0);
    send(1'b0, 9'h03C, 8, -1, 1'b1, 1'b1);
    expect_word(1'b0, "post_reset", 9'h03C, 1'b0, 1'b0);

    repeat (10) @(posedge internal_clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
